egress_grant_sched: RTL and testbench
=====================================

Name: egress_grant_sched

Overview:
- Egress-side grant scheduler for the 4x4 VOQ crossbar. It is the responder to the ingress-side VOQ picker.
- Each ingress presents one request per iteration (the egress its picker chose). Each egress grants at most one requesting ingress, using a round-robin pointer per egress.
- Grants accumulate over up to MAX_ITER iterations into a crossbar match.
- egress_taken is fed back to the ingress pickers as their "already picked" mask.

Parameters:
MAX_ITER, 3, maximum request/grant iterations per matching round (1..4)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
sched_start  in  1  1-cycle pulse that begins a matching round; honoured only in IDLE
req_valid  in  1  request vector valid; transfers when req_valid && req_ready
req_ready  out  1  high only in COLLECT
req_active  in  4  bit i: ingress i has a request this iteration
req_egress  in  8  [2i+1:2i]: egress requested by ingress i
grant_valid  out  1  high in GRANT; held until grant_ready
grant_ready  in  1  ingress side accepts the grant set
grant_mask  out  4  egresses granted in the current iteration
grant_ingress  out  8  [2e+1:2e]: ingress granted by egress e (valid where grant_mask[e])
egress_taken  out  4  egresses matched so far this round
ingress_matched  out  4  ingresses matched so far this round
match_done  out  1  1-cycle pulse at round end
match_map  out  8  [2e+1:2e]: final ingress for egress e; stable from match_done until next sched_start
match_egress_valid  out  4  final matched-egress mask
iter_count  out  2  current iteration index (0-based)
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert):
  - State goes to IDLE.
  - All outputs are 0.
  - All 4 per-egress pointers are 0.
  - egress_taken, ingress_matched, match_map and iter_count are cleared.
  - Reset mid-round abandons the round; no match_done is produced.
- FSM states: IDLE, COLLECT, ARB, GRANT, DONE.
- IDLE: on sched_start, clear egress_taken, ingress_matched and iter_count, then go to COLLECT next cycle.
- COLLECT: req_ready=1. On handshake, latch req_active/req_egress and go to ARB.
- ARB (1 cycle):
  - For each egress e, candidate ingress i requires: req_active[i], req_egress[i]==e, !ingress_matched[i], !egress_taken[e].
  - Grant the first candidate scanning i = ptr[e], ptr[e]+1, ... mod 4.
  - Register grant_mask/grant_ingress.
  - If grant_mask==0, go to DONE (no progress); otherwise go to GRANT.
- GRANT:
  - grant_valid=1; grant_mask and grant_ingress are held stable until handshake.
  - On grant_valid && grant_ready:
    - egress_taken |= grant_mask, and ingress_matched gains the granted ingresses.
    - match_map is updated for the granted egresses.
    - If iter_count==0 only: ptr[e] <= (grant_ingress[e]+1) mod 4 for each granted e. Pointers are never moved in later iterations.
  - Next state after handshake: DONE if iter_count==MAX_ITER-1, or ingress_matched==4'hF, or egress_taken==4'hF (evaluated on updated values). Otherwise iter_count++ and go to COLLECT.
- DONE (1 cycle): match_done=1; match_map/match_egress_valid reflect the accumulated match. Then go to IDLE.
- Latency:
  - sched_start at cycle t gives req_ready at t+1.
  - Request handshake at cycle k gives grant_valid at k+2 (ARB occupies k+1).
- Boundary and ignore rules:
  - sched_start outside IDLE (including in DONE) is ignored.
  - Requests from already-matched ingresses, or to taken egresses, are silently ignored.
  - req_active==0 produces an empty grant, then DONE.
  - Pointer arithmetic is 2-bit with natural wrap (3+1 -> 0).
  - Several ingresses may request the same egress; distinct egresses are arbitrated independently in the same cycle.

Decomposition:
- Shared package sched_pkg holds:
  - N_PORT=4, PORT_W=2
  - port_idx_t (logic [1:0])
  - port_mask_t (logic [3:0])
  - the sched_state_t enum, shared with the future ingress-side sequencer
- Sub-module rr_grant_arb: combinational, one instance per egress.
  - Inputs: ptr, 4-bit candidate mask.
  - Outputs: grant_any, grant_idx.
  - It is the grant-side mirror of the ingress VOQ picker.

Test Plan:
- Reset, then start; requests i->egress i for all 4 ingresses; grant_ready=1 -> grant_mask=1111, grant_ingress=8'hE4 (e3:3, e2:2, e1:1, e0:0), match_done one cycle later, ptrs become {0,3,2,1} (e3..e0).
- Fresh reset; all ingresses request egress 2 -> grant ingress 0 (ptr[2]=0). Iteration 1 re-requests egress 2 -> empty grant, DONE, match_egress_valid=0100. Second round with the same requests grants ingress 1.
- Iteration 0: ingresses 0 and 1 both request e0 -> ingress 0 granted. Iteration 1: ingress 1 requests e1 -> granted, but ptr[1] stays 0 and ptr[0] becomes 1.
- MAX_ITER=3: one grant per iteration on distinct egresses -> exactly 3 GRANT handshakes, iter_count reaches 2, then match_done with 3 bits set in match_egress_valid.
- Hold grant_ready=0 for 5 cycles -> grant_valid, grant_mask and grant_ingress stay stable. Then assert reset_n=0 mid-GRANT -> all outputs 0 immediately (async), state IDLE, no match_done.
- sched_start pulsed while busy -> ignored (iter_count and state unchanged). req_valid with req_active=0 -> empty grant, match_done with match_egress_valid=0.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared scheduler types for the 4x4 VOQ crossbar (egress grant side and ingress sequencer).
package sched_pkg;
    localparam int N_PORT = 4;
    localparam int PORT_W = 2;

    typedef logic [PORT_W-1:0] port_idx_t;
    typedef logic [N_PORT-1:0] port_mask_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ARB,
        S_GRANT,
        S_DONE
    } sched_state_t;
endpackage

// File: rtl/rr_grant_arb.sv
// Round-robin pick of one candidate ingress for a single egress, scanning upward from ptr_i.
module rr_grant_arb
    import sched_pkg::*;
(
    input  port_idx_t  ptr_i,
    input  port_mask_t cand_i,
    output logic       grant_any_o,
    output port_idx_t  grant_idx_o
);
    port_idx_t idx;

    // Scan from the farthest offset down so the nearest candidate to ptr_i wins.
    always_comb begin
        grant_any_o = 1'b0;
        grant_idx_o = '0;
        idx         = '0;
        for (int k = N_PORT - 1; k >= 0; k--) begin
            idx = ptr_i + port_idx_t'(k);
            if (cand_i[idx]) begin
                grant_any_o = 1'b1;
                grant_idx_o = idx;
            end
        end
    end
endmodule

// File: rtl/egress_grant_sched.sv
// Egress-side grant scheduler: per-egress round-robin grants accumulated over MAX_ITER
// request/grant iterations into a crossbar match.
module egress_grant_sched
    import sched_pkg::*;
#(
    parameter int MAX_ITER = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sched_start,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_active,
    input  logic [7:0] req_egress,
    output logic       grant_valid,
    input  logic       grant_ready,
    output logic [3:0] grant_mask,
    output logic [7:0] grant_ingress,
    output logic [3:0] egress_taken,
    output logic [3:0] ingress_matched,
    output logic       match_done,
    output logic [7:0] match_map,
    output logic [3:0] match_egress_valid,
    output logic [1:0] iter_count,
    output logic       busy
);
    sched_state_t                        state_q, state_d;
    logic [N_PORT-1:0][PORT_W-1:0]       ptr_q, ptr_d;
    port_mask_t                          req_act_q, req_act_d;
    logic [N_PORT-1:0][PORT_W-1:0]       req_egr_q, req_egr_d;
    port_mask_t                          taken_q, taken_d;
    port_mask_t                          matched_q, matched_d;
    port_mask_t                          gmask_q, gmask_d;
    logic [N_PORT-1:0][PORT_W-1:0]       ging_q, ging_d;
    logic [N_PORT-1:0][PORT_W-1:0]       map_q, map_d;
    logic [1:0]                          iter_q, iter_d;

    logic [N_PORT-1:0][N_PORT-1:0]       cand;      // [egress][ingress]
    port_mask_t                          arb_any;
    logic [N_PORT-1:0][PORT_W-1:0]       arb_idx;
    port_mask_t                          granted_ing, taken_upd, matched_upd;

    for (genvar e = 0; e < N_PORT; e++) begin : g_egress
        for (genvar i = 0; i < N_PORT; i++) begin : g_cand
            assign cand[e][i] = req_act_q[i] && (req_egr_q[i] == port_idx_t'(e)) &&
                                !matched_q[i] && !taken_q[e];
        end
        rr_grant_arb u_arb (
            .ptr_i       (ptr_q[e]),
            .cand_i      (cand[e]),
            .grant_any_o (arb_any[e]),
            .grant_idx_o (arb_idx[e])
        );
    end

    always_comb begin
        granted_ing = '0;
        for (int e = 0; e < N_PORT; e++) begin
            if (gmask_q[e]) granted_ing[ging_q[e]] = 1'b1;
        end
        taken_upd   = taken_q | gmask_q;
        matched_upd = matched_q | granted_ing;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        req_act_d = req_act_q;
        req_egr_d = req_egr_q;
        taken_d   = taken_q;
        matched_d = matched_q;
        gmask_d   = gmask_q;
        ging_d    = ging_q;
        map_d     = map_q;
        iter_d    = iter_q;
        case (state_q)
            S_IDLE: if (sched_start) begin
                taken_d   = '0;
                matched_d = '0;
                iter_d    = '0;
                map_d     = '0;
                state_d   = S_COLLECT;
            end
            S_COLLECT: if (req_valid) begin
                req_act_d = req_active;
                req_egr_d = req_egress;
                state_d   = S_ARB;
            end
            S_ARB: begin
                gmask_d = arb_any;
                for (int e = 0; e < N_PORT; e++) ging_d[e] = arb_any[e] ? arb_idx[e] : '0;
                state_d = (arb_any == '0) ? S_DONE : S_GRANT;
            end
            S_GRANT: if (grant_ready) begin
                taken_d   = taken_upd;
                matched_d = matched_upd;
                for (int e = 0; e < N_PORT; e++) begin
                    if (gmask_q[e]) begin
                        map_d[e] = ging_q[e];
                        // Only first-iteration grants advance the pointers, keeping RR fairness stable.
                        if (iter_q == 2'd0) ptr_d[e] = ging_q[e] + port_idx_t'(1);
                    end
                end
                if (iter_q == 2'(MAX_ITER - 1) || matched_upd == '1 || taken_upd == '1) begin
                    state_d = S_DONE;
                end else begin
                    iter_d  = iter_q + 2'd1;
                    state_d = S_COLLECT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            req_act_q <= '0;
            req_egr_q <= '0;
            taken_q   <= '0;
            matched_q <= '0;
            gmask_q   <= '0;
            ging_q    <= '0;
            map_q     <= '0;
            iter_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            req_act_q <= req_act_d;
            req_egr_q <= req_egr_d;
            taken_q   <= taken_d;
            matched_q <= matched_d;
            gmask_q   <= gmask_d;
            ging_q    <= ging_d;
            map_q     <= map_d;
            iter_q    <= iter_d;
        end
    end

    assign req_ready          = (state_q == S_COLLECT);
    assign grant_valid        = (state_q == S_GRANT);
    assign match_done         = (state_q == S_DONE);
    assign busy               = (state_q != S_IDLE);
    assign grant_mask         = gmask_q;
    assign grant_ingress      = ging_q;
    assign egress_taken       = taken_q;
    assign ingress_matched    = matched_q;
    assign match_map          = map_q;
    assign match_egress_valid = taken_q;
    assign iter_count         = iter_q;
endmodule

// File: tb/tb_egress_grant_sched.sv
// Directed bench for egress_grant_sched: stimulus pushes expected grants/matches, a monitor checks them.
module tb_egress_grant_sched;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sched_start = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_active = '0;
    logic [7:0] req_egress = '0;
    logic       grant_valid;
    logic       grant_ready = 1'b0;
    logic [3:0] grant_mask;
    logic [7:0] grant_ingress;
    logic [3:0] egress_taken;
    logic [3:0] ingress_matched;
    logic       match_done;
    logic [7:0] match_map;
    logic [3:0] match_egress_valid;
    logic [1:0] iter_count;
    logic       busy;

    egress_grant_sched #(.MAX_ITER(3)) dut (
        .clk(clk), .reset_n(reset_n), .sched_start(sched_start),
        .req_valid(req_valid), .req_ready(req_ready), .req_active(req_active),
        .req_egress(req_egress), .grant_valid(grant_valid), .grant_ready(grant_ready),
        .grant_mask(grant_mask), .grant_ingress(grant_ingress),
        .egress_taken(egress_taken), .ingress_matched(ingress_matched),
        .match_done(match_done), .match_map(match_map),
        .match_egress_valid(match_egress_valid), .iter_count(iter_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [3:0] mask; logic [7:0] ing; } gexp_t;
    typedef struct packed { logic [7:0] map;  logic [3:0] ev;  } dexp_t;
    gexp_t exp_g[$];
    dexp_t exp_d[$];
    gexp_t ge;
    dexp_t de;

    int n_vec = 0, n_err = 0, done_seen = 0, grant_hs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: checks every grant handshake and every match_done against the queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (grant_valid && grant_ready) begin
                grant_hs++;
                if (exp_g.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_grant: got mask %0h ingress %0h, expected none", grant_mask, grant_ingress);
                end else begin
                    ge = exp_g.pop_front();
                    chk("grant_mask", 32'(grant_mask), 32'(ge.mask));
                    chk("grant_ingress", 32'(grant_ingress), 32'(ge.ing));
                end
            end
            if (match_done) begin
                done_seen++;
                if (exp_d.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_done: got map %0h valid %0h, expected none", match_map, match_egress_valid);
                end else begin
                    de = exp_d.pop_front();
                    chk("match_map", 32'(match_map), 32'(de.map));
                    chk("match_egress_valid", 32'(match_egress_valid), 32'(de.ev));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 32'({grant_valid, req_ready, match_done, busy, iter_count}), 32'h0);
        chk({tag, "_data"}, {grant_mask, grant_ingress, egress_taken, ingress_matched, match_map},  32'h0);
        chk({tag, "_mev"}, 32'(match_egress_valid), 32'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; sched_start = 1'b0; req_valid = 1'b0;
        #3;
        chk_all_zero("reset");
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic start_round();
        sched_start = 1'b1;
        tick();
        sched_start = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        if (!req_ready) begin
            n_vec++; n_err++;
            $display("FAIL req_ready_timeout: got req_ready 0, expected 1 within 50 cycles");
        end
    endtask

    task automatic send_req(input logic [3:0] act, input logic [7:0] egr);
        wait_ready();
        req_valid = 1'b1; req_active = act; req_egress = egr;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin tick(); n++; end
        if (busy) begin
            n_vec++; n_err++;
            $display("FAIL idle_timeout: got busy 1, expected 0 within 50 cycles");
        end
    endtask

    task automatic push_g(input logic [3:0] m, input logic [7:0] g); exp_g.push_back({m, g}); endtask
    task automatic push_d(input logic [7:0] m, input logic [3:0] v); exp_d.push_back({m, v}); endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, d0;
        // Test 1: identity match, then pointers advanced to ptr[e]=e+1.
        do_reset();
        grant_ready = 1'b1;
        start_round();
        chk("start_to_ready", 32'(req_ready), 32'h1);
        push_g(4'hF, 8'hE4); push_d(8'hE4, 4'hF);
        send_req(4'hF, 8'hE4);
        wait_idle();
        start_round();
        push_g(4'h1, 8'h01);                   // ptr[0]=1 -> ingress 1
        send_req(4'hF, 8'h00);
        push_d(8'h01, 4'h1);
        send_req(4'hF, 8'h00);                 // e0 taken -> empty grant
        wait_idle();

        // Test 2: contention on egress 2 across two rounds.
        do_reset();
        start_round();
        push_g(4'h4, 8'h00);
        send_req(4'hF, 8'hAA);
        push_d(8'h00, 4'h4);
        send_req(4'hF, 8'hAA);
        wait_idle();
        start_round();
        push_g(4'h4, 8'h10);
        send_req(4'hF, 8'hAA);
        push_d(8'h10, 4'h4);
        send_req(4'hF, 8'hAA);
        wait_idle();

        // Test 3: only first-iteration grants move pointers (ptr[0]->1, ptr[1] stays 0).
        do_reset();
        start_round();
        push_g(4'h1, 8'h00);
        send_req(4'h3, 8'h00);
        push_g(4'h2, 8'h04);
        send_req(4'h2, 8'h04);
        push_d(8'h04, 4'h3);
        send_req(4'h0, 8'h00);
        wait_idle();
        start_round();
        push_g(4'h3, 8'h06);                   // e0 -> ingress 2, e1 -> ingress 1
        send_req(4'hF, 8'h44);
        push_d(8'h06, 4'h3);
        send_req(4'h0, 8'h00);
        wait_idle();

        // Test 4: iteration limit ends the round after three grants.
        do_reset();
        start_round();
        h0 = grant_hs;
        push_g(4'h1, 8'h00); send_req(4'h1, 8'h00);
        push_g(4'h2, 8'h04); send_req(4'h2, 8'h04);
        push_g(4'h4, 8'h20); send_req(4'h4, 8'h20);
        push_d(8'h24, 4'h7);
        tick();
        chk("last_iter_grant_valid", 32'(grant_valid), 32'h1);
        chk("last_iter_count", 32'(iter_count), 32'h2);
        wait_idle();
        chk("max_iter_grant_count", 32'(grant_hs - h0), 32'h3);

        // Test 5: grant held under backpressure, then async reset mid-GRANT.
        do_reset();
        grant_ready = 1'b0;
        start_round();
        send_req(4'h8, 8'h40);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("hold_grant_valid", 32'(grant_valid), 32'h1);
            chk("hold_grant_mask", 32'(grant_mask), 32'h2);
            chk("hold_grant_ingress", 32'(grant_ingress), 32'h0C);
            tick();
        end
        d0 = done_seen;
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_reset");
        tick(); tick(); tick();
        chk("no_done_after_reset", 32'(done_seen - d0), 32'h0);
        reset_n = 1'b1;
        grant_ready = 1'b1;
        tick();

        // Test 6: sched_start ignored while busy; empty request ends the round.
        do_reset();
        start_round();
        push_g(4'h1, 8'h00);
        send_req(4'h1, 8'h00);
        wait_ready();
        sched_start = 1'b1;
        tick();
        sched_start = 1'b0;
        chk("start_busy_iter", 32'(iter_count), 32'h1);
        chk("start_busy_ready", 32'(req_ready), 32'h1);
        chk("start_busy_taken", 32'(egress_taken), 32'h1);
        push_d(8'h00, 4'h1);
        send_req(4'h0, 8'h00);
        sched_start = 1'b1;                    // held through ARB and DONE
        tick(); tick();
        sched_start = 1'b0;
        chk("start_in_done_busy", 32'(busy), 32'h0);
        chk("start_in_done_ready", 32'(req_ready), 32'h0);
        start_round();
        push_d(8'h00, 4'h0);
        send_req(4'h0, 8'h00);
        wait_idle();
        chk("empty_round_taken", 32'(egress_taken), 32'h0);

        tick(); tick();
        chk("grant_queue_drained", 32'(exp_g.size()), 32'h0);
        chk("done_queue_drained", 32'(exp_d.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
